// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver.
//   tx_state_e  : frame FSM state (IDLE, START, DATA, STOP)
//   LINE_IDLE   : level held on the line between frames
//   START_LEVEL : level of the start bit
//   STOP_LEVEL  : level of the stop bit
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_bit_period_counter.sv
// Bit-period counter shared by the serial transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and wraps; `clear` forces the count back to 0.
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   clear : restart the bit period on the next edge
//   tick  : high while the count is CLKS_PER_BIT-1 (last cycle of a bit)
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With CLKS_PER_BIT=1 the count is always 0 and tick is permanently high.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits
// LSB-first, stop bit, each bit held CLKS_PER_BIT clock cycles.
//   clock      : rising-edge system clock
//   reset      : asynchronous, active-low reset
//   load_valid : word on load_data is offered
//   load_data  : word to transmit
//   load_ready : block accepts a word this cycle (IDLE only)
//   ser_out    : serial line, idles high
//   busy       : frame in progress
//   done       : one-cycle pulse on the last stop-bit cycle
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             tick;
  logic             clear;

  bit_period_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_period_counter (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    case (state_q)
      IDLE: begin
        if (load_valid && ready_q) begin
          shift_d = load_data;
          state_d = START;
        end
      end
      START: begin
        if (tick) state_d = START == START ? DATA : DATA;
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Both counters restart at every state change; the period counter is
    // also held at 0 while idle so the start bit gets a full period.
    if (state_d != state_q) begin
      bit_idx_d = '0;
    end
    clear = (state_d != state_q) || (state_q == IDLE);

    // Line level and status are computed from the next state so that the
    // pins come straight from flops and cannot glitch.
    case (state_d)
      START:   ser_d = START_LEVEL;
      DATA:    ser_d = shift_d[0];
      STOP:    ser_d = STOP_LEVEL;
      default: ser_d = LINE_IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ser_q     <= LINE_IDLE;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign ser_out    = ser_q;
  assign busy       = busy_q;
  assign load_ready = ready_q;
  // done decodes only flops (state and period counter), never an input.
  assign done       = (state_q == STOP) && tick;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  localparam int W = 8;
  localparam int C = 4;
  localparam int N = (W + 2) * C;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         lv = 1'b0;
  logic [W-1:0] ld = '0;
  logic         ready, ser, busy, done;

  logic         lv1 = 1'b0;
  logic [0:0]   ld1 = 1'b0;
  logic         ready1, ser1, busy1, done1;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clock(clock), .reset(reset), .load_valid(lv), .load_data(ld),
    .load_ready(ready), .ser_out(ser), .busy(busy), .done(done)
  );

  serial_frame_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .clock(clock), .reset(reset), .load_valid(lv1), .load_data(ld1),
    .load_ready(ready1), .ser_out(ser1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of N line slots indexed by m_p.
  // Slot s = m_p / C: 0 is the start bit, 1..W are data bits, W+1 is stop.
  bit           m_active = 1'b0;
  int           m_p = 0;
  logic [W-1:0] m_word = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_p      <= 0;
    end else if (m_active) begin
      if (m_p == N - 1) m_active <= 1'b0;
      m_p <= m_p + 1;
    end else if (lv) begin
      m_active <= 1'b1;
      m_p      <= 0;
      m_word   <= ld;
    end
  end

  always @(negedge clock) begin : line_check
    int   slot;
    logic e_ser, e_busy, e_ready, e_done;
    if (chk_en) begin
      e_ser = 1'b1; e_busy = 1'b0; e_ready = 1'b1; e_done = 1'b0;
      if (m_active) begin
        slot    = m_p / C;
        e_busy  = 1'b1;
        e_ready = 1'b0;
        e_done  = (m_p == N - 1);
        if (slot == 0)      e_ser = 1'b0;
        else if (slot <= W) e_ser = m_word[slot-1];
        else                e_ser = 1'b1;
      end
      check_eq("ser_out", ser, e_ser);
      check_eq("busy", busy, e_busy);
      check_eq("load_ready", ready, e_ready);
      check_eq("done", done, e_done);
    end
  end

  // Offer a word and keep offering until the model has accepted it.
  task automatic offer(input logic [W-1:0] d);
    bit took;
    took = 1'b0;
    lv = 1'b1;
    ld = d;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (m_active && m_p == 0) begin
        took = 1'b1;
        break;
      end
    end
    lv = 1'b0;
    check_eq("accept_busy", busy, took);
  endtask

  initial begin
    // Reset held: line idles, valid ignored.
    chk_en = 1'b1;
    repeat (3) @(posedge clock);
    #1 lv = 1'b1; ld = 8'hFF;
    @(posedge clock);
    #1 lv = 1'b0;
    check_eq("rst_ser", ser, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_ser1", ser1, 1);
    check_eq("rst_ready1", ready1, 1);
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;

    // Single frame.
    offer(8'hA5);
    repeat (N + 2) @(posedge clock);
    #1;

    // Back-to-back with valid held.
    offer(8'h01);
    offer(8'h80);
    repeat (N + 2) @(posedge clock);
    #1;

    // Load attempt while busy.
    offer(8'hC3);
    repeat (12) @(posedge clock);
    #1 lv = 1'b1; ld = 8'h00;
    @(posedge clock);
    #1 lv = 1'b0;
    repeat (N) @(posedge clock);
    #1;

    // Asynchronous reset mid-frame, during data bit 3.
    offer(8'h00);
    repeat (17) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check_eq("arst_ser", ser, 1);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ready", ready, 1);
    check_eq("arst_done", done, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    offer(8'h5A);
    repeat (N + 2) @(posedge clock);
    #1;

    // Random traffic: valid and data change freely, including mid-frame.
    repeat (1500) begin
      @(posedge clock);
      #1;
      lv = ($urandom_range(0, 3) == 0);
      ld = W'($urandom);
    end
    lv = 1'b0;
    repeat (N + 2) @(posedge clock);
    #1;

    // One-bit word, one clock per bit.
    lv1 = 1'b1; ld1 = 1'b1;
    @(posedge clock);
    #1 lv1 = 1'b0;
    @(negedge clock);
    check_eq("w1_c1_ser", ser1, 0);
    check_eq("w1_c1_busy", busy1, 1);
    check_eq("w1_c1_done", done1, 0);
    @(negedge clock);
    check_eq("w1_c2_ser", ser1, 1);
    check_eq("w1_c2_done", done1, 0);
    @(negedge clock);
    check_eq("w1_c3_ser", ser1, 1);
    check_eq("w1_c3_done", done1, 1);
    @(negedge clock);
    check_eq("w1_c4_ready", ready1, 1);
    check_eq("w1_c4_busy", busy1, 0);
    check_eq("w1_c4_done", done1, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
